pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed inter-stage pipeline register, e.g. EX/MEM.
- Carries PC, instruction, NFIELD 32-bit payload fields and an exception code between two pipeline stages.
- Uses valid/ready handshakes and a 2-entry skid buffer, so upstream ready is registered and does not depend combinationally on downstream stall.
- Provides flush-to-kernel on interrupt/exception, overflow-to-exception merging, and an N-way forward-source mux for the hazard unit.

Parameters:
- NFIELD, 2, number of 32-bit payload fields (field 0 = ALU/CAL result).
- EXC_W, 5, exception code width; code 0 means no exception.
- OVF_EXC, 12, exception code inserted on arithmetic overflow.
- OVF_EN, 1, 1 enables overflow-to-exception merging; 0 ignores in_ovf.
- SEL_W, 3, forward select width; must satisfy 2^SEL_W > NFIELD+1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  interrupt/exception request; squashes all stored entries.
- flush_pc  in  32  PC loaded on flush (kernel entry, 0x4180 in system use).
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_pc  in  32  entry PC.
- in_instr  in  32  entry instruction.
- in_data  in  32*NFIELD  payload; field k occupies bits [32k+31:32k].
- in_exc  in  EXC_W  incoming exception code.
- in_ovf  in  1  overflow flag from ALU.
- in_bd  in  1  entry is in a delay slot.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_pc, out_instr  out  32 each  head PC/instruction.
- out_data  out  32*NFIELD  head payload.
- out_exc  out  EXC_W  head exception code after merging.
- out_bd  out  1  head delay-slot flag.
- out_count  out  2  stored entries (0..2).
- fwd_sel  in  SEL_W  forward source select.
- fwd_src  out  32  forwarded value.

Behaviour:
- Storage: head register H and skid register S, each with a valid bit.
- Priority each cycle: reset > flush > normal.
- Reset:
  - H.valid = S.valid = 0.
  - All stored fields, including bd and exc, cleared to 0.
  - Visible result: out_pc=0, out_instr=0, out_data=0, out_exc=0, out_bd=0, out_count=0, in_ready=1.
- Flush:
  - H.valid = S.valid = 0.
  - H.pc = flush_pc; H.instr, data, exc and bd = 0; S contents cleared.
  - An input offered in the same cycle is dropped.
  - in_ready = 1 in the following cycle.
- in_ready is registered and equals !S.valid. An accept occurs on in_valid & in_ready.
- Head advances (adv) when !H.valid | out_ready:
  - If S.valid: H <= S and S.valid <= 0; an accepted input in the same cycle goes to S.
  - Else if accept: H <= input.
  - Else: H.valid <= 0; fields hold.
- When !adv and accept, S <= input (skid capture). in_ready drops next cycle.
- Latency: 1 cycle from accept to out_valid when the stage is empty; throughput 1 entry/cycle when out_ready is held high.
- Exception merge at capture: stored exc = in_exc if in_exc != 0; else OVF_EXC if OVF_EN & in_ovf; else 0. An earlier-stage exception always wins.
- out_* reflect H combinationally from registers; there is no combinational path from input to output.
- out_count = H.valid + S.valid.
- fwd_sel decode:
  - k < NFIELD: field k of H.
  - k == NFIELD: H.pc + 8, with 32-bit wrap.
  - Any other value: 0. This covers the memory-read-not-yet-available case.
  - fwd_src is valid only when out_valid = 1; the hazard unit must gate it.
- Illegal state (S.valid & !H.valid) is unreachable; verification asserts it never occurs.

Decomposition:
- Shared header holds:
  - PC_kernel;
  - forward select codes (fwd_src_CALres = 0, fwd_src_PC8 = NFIELD, fwd_src_DM_RD = zero code);
  - exception codes (Ov = 12).
- One sub-module, stage_entry_reg: a single entry register with valid bit, load, clear-to-PC and merge logic, instantiated twice for H and S.

Test Plan:
1. reset=1 for 2 cycles, then in_valid=1, pc=0x3000, data[0]=0x5 -> cycle after accept: out_valid=1, out_pc=0x3000, out_count=1; fwd_sel=0 gives 0x5, fwd_sel=NFIELD gives 0x3008.
2. out_ready=0; accept pc 0x3000 then 0x3004 -> out_count=2, in_ready=0; third input held. out_ready=1 -> out_pc order is 0x3000, 0x3004, then the held entry, with none lost or duplicated.
3. Stage full with pc 0x3000/0x3004 plus an input offered and flush=1 -> next cycle out_valid=0, out_pc=0x4180, out_instr=0, out_count=0, in_ready=1; offered input is absent from every later output.
4. in_exc=0, in_ovf=1 -> out_exc=12. in_exc=4, in_ovf=1 -> out_exc=4. With OVF_EN=0, in_ovf=1 -> out_exc=0.
5. fwd_sel=7 (unused) -> fwd_src=0. pc=0xFFFFFFFC with fwd_sel=NFIELD -> 0x00000004.
6. Continuous in_valid and out_ready for 16 cycles -> 16 entries out, in order, in_ready=1 throughout, out_count=1; reset asserted mid-stream -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf_pkg
// Shared definitions for the inter-stage pipeline buffer.
//   PC_KERNEL       : kernel entry PC normally driven onto flush_pc
//   FWD_SRC_CALRES  : forward select code of the ALU/CAL result (field 0)
//   EXC_NONE/EXC_OV : exception codes (no exception / arithmetic overflow)
//   h_src_e         : which source the head register loads from
//   merge_exc       : exception merge rule applied when an entry is captured
//   pc_plus8        : link value offered to the forward mux
// The PC+8 forward code equals NFIELD and the memory-read code is any value
// above it; both depend on the instance parameters, so the top defines them.
// ---------------------------------------------------------------------------
package pipe_stage_buf_pkg;

  localparam logic [31:0] PC_KERNEL      = 32'h0000_4180;
  localparam int          FWD_SRC_CALRES = 0;
  localparam int          EXC_NONE       = 0;
  localparam int          EXC_OV         = 12;

  typedef enum logic [1:0] {
    H_SRC_NONE = 2'd0,
    H_SRC_SKID = 2'd1,
    H_SRC_IN   = 2'd2
  } h_src_e;

  // An exception raised by an earlier stage always wins over overflow.
  function automatic logic [31:0] merge_exc(input logic [31:0] exc,
                                            input logic        ovf,
                                            input logic        ovf_en,
                                            input logic [31:0] ovf_code);
    logic [31:0] res;
    res = 32'(EXC_NONE);
    if (exc != 32'(EXC_NONE))
      res = exc;
    else if (ovf_en && ovf)
      res = ovf_code;
    return res;
  endfunction

  function automatic logic [31:0] pc_plus8(input logic [31:0] pc);
    return pc + 32'd8;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_entry.sv
// ---------------------------------------------------------------------------
// stage_entry_reg
// One pipeline entry (valid bit + PC, instruction, payload, exception, bd).
// Priority: reset > clear > load > kill.
//   clk, reset   : clock, synchronous active-high reset (clears everything)
//   i_clr        : squash entry; valid=0, pc=i_clr_pc, all other fields 0
//   i_clr_pc     : PC loaded by i_clr
//   i_load       : capture i_* fields, valid=1, exception merged on capture
//   i_kill       : drop valid only; stored fields hold
//   i_pc..i_bd   : entry fields to capture
//   o_valid..o_bd: stored entry
// ---------------------------------------------------------------------------
module stage_entry_reg
  import pipe_stage_buf_pkg::*;
#(
  parameter int NFIELD  = 2,
  parameter int EXC_W   = 5,
  parameter int OVF_EXC = EXC_OV,
  parameter int OVF_EN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clr,
  input  logic [31:0]           i_clr_pc,
  input  logic                  i_load,
  input  logic                  i_kill,
  input  logic [31:0]           i_pc,
  input  logic [31:0]           i_instr,
  input  logic [32*NFIELD-1:0]  i_data,
  input  logic [EXC_W-1:0]      i_exc,
  input  logic                  i_ovf,
  input  logic                  i_bd,
  output logic                  o_valid,
  output logic [31:0]           o_pc,
  output logic [31:0]           o_instr,
  output logic [32*NFIELD-1:0]  o_data,
  output logic [EXC_W-1:0]      o_exc,
  output logic                  o_bd
);

  logic                  r_valid;
  logic [31:0]           r_pc;
  logic [31:0]           r_instr;
  logic [32*NFIELD-1:0]  r_data;
  logic [EXC_W-1:0]      r_exc;
  logic                  r_bd;
  logic [31:0]           w_exc_merged;

  assign w_exc_merged = merge_exc(32'(i_exc), i_ovf, (OVF_EN != 0), 32'(OVF_EXC));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
      r_data  <= '0;
      r_exc   <= '0;
      r_bd    <= 1'b0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_pc    <= i_clr_pc;
      r_instr <= '0;
      r_data  <= '0;
      r_exc   <= '0;
      r_bd    <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_data  <= i_data;
      r_exc   <= w_exc_merged[EXC_W-1:0];
      r_bd    <= i_bd;
    end else if (i_kill) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_data  = r_data;
  assign o_exc   = r_exc;
  assign o_bd    = r_bd;

endmodule

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
// Inter-stage pipeline register with valid/ready handshakes and a 2-entry
// skid buffer (head H, skid S). in_ready is a register output (!S.valid), so
// upstream never sees a combinational path from out_ready.
//   clk, reset            : clock, synchronous active-high reset
//   flush, flush_pc       : squash all entries, head PC <= flush_pc
//   in_valid/in_ready     : upstream handshake
//   in_pc..in_bd          : incoming entry (in_ovf merged into exc on capture)
//   out_valid/out_ready   : downstream handshake
//   out_pc..out_bd        : head entry
//   out_count             : stored entries (0..2)
//   fwd_sel/fwd_src       : forward mux for the hazard unit
//                           (k<NFIELD: field k, NFIELD: pc+8, else 0)
// ---------------------------------------------------------------------------
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int NFIELD  = 2,
  parameter int EXC_W   = 5,
  parameter int OVF_EXC = EXC_OV,
  parameter int OVF_EN  = 1,
  parameter int SEL_W   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [31:0]           flush_pc,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic [31:0]           in_instr,
  input  logic [32*NFIELD-1:0]  in_data,
  input  logic [EXC_W-1:0]      in_exc,
  input  logic                  in_ovf,
  input  logic                  in_bd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_instr,
  output logic [32*NFIELD-1:0]  out_data,
  output logic [EXC_W-1:0]      out_exc,
  output logic                  out_bd,
  output logic [1:0]            out_count,
  input  logic [SEL_W-1:0]      fwd_sel,
  output logic [31:0]           fwd_src
);

  localparam int FWD_SRC_PC8 = NFIELD;

  // Head register outputs
  logic                  w_h_valid;
  logic [31:0]           w_h_pc;
  logic [31:0]           w_h_instr;
  logic [32*NFIELD-1:0]  w_h_data;
  logic [EXC_W-1:0]      w_h_exc;
  logic                  w_h_bd;

  // Skid register outputs
  logic                  w_s_valid;
  logic [31:0]           w_s_pc;
  logic [31:0]           w_s_instr;
  logic [32*NFIELD-1:0]  w_s_data;
  logic [EXC_W-1:0]      w_s_exc;
  logic                  w_s_bd;

  // Head load mux
  h_src_e                w_h_src;
  logic [31:0]           w_hn_pc;
  logic [31:0]           w_hn_instr;
  logic [32*NFIELD-1:0]  w_hn_data;
  logic [EXC_W-1:0]      w_hn_exc;
  logic                  w_hn_ovf;
  logic                  w_hn_bd;

  logic                  w_accept;
  logic                  w_adv;
  logic                  w_h_load;
  logic                  w_h_kill;
  logic                  w_s_load;
  logic                  w_s_kill;
  logic [31:0]           w_fwd;

  // Control: handshake and advance decisions
  assign in_ready = ~w_s_valid;
  assign w_accept = in_valid & in_ready & ~flush;
  assign w_adv    = ~w_h_valid | out_ready;

  assign w_h_load = w_adv & (w_s_valid | w_accept);
  assign w_h_kill = w_adv & ~w_s_valid & ~w_accept;
  // Skid captures when the head is stalled; the s_valid term keeps an input
  // arriving while S drains to H from being lost.
  assign w_s_load = w_accept & (~w_adv | w_s_valid);
  assign w_s_kill = w_adv & w_s_valid & ~w_accept;

  always_comb begin
    w_h_src = H_SRC_NONE;
    if (w_h_load)
      w_h_src = w_s_valid ? H_SRC_SKID : H_SRC_IN;
  end

  // Skid entries were already merged on capture, so ovf is forced low to
  // pass their exception code through unchanged.
  always_comb begin
    w_hn_pc    = in_pc;
    w_hn_instr = in_instr;
    w_hn_data  = in_data;
    w_hn_exc   = in_exc;
    w_hn_ovf   = in_ovf;
    w_hn_bd    = in_bd;
    if (w_h_src == H_SRC_SKID) begin
      w_hn_pc    = w_s_pc;
      w_hn_instr = w_s_instr;
      w_hn_data  = w_s_data;
      w_hn_exc   = w_s_exc;
      w_hn_ovf   = 1'b0;
      w_hn_bd    = w_s_bd;
    end
  end

  // Stage: head register
  stage_entry_reg #(
    .NFIELD  (NFIELD),
    .EXC_W   (EXC_W),
    .OVF_EXC (OVF_EXC),
    .OVF_EN  (OVF_EN)
  ) u_head (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (flush),
    .i_clr_pc (flush_pc),
    .i_load   (w_h_src != H_SRC_NONE),
    .i_kill   (w_h_kill),
    .i_pc     (w_hn_pc),
    .i_instr  (w_hn_instr),
    .i_data   (w_hn_data),
    .i_exc    (w_hn_exc),
    .i_ovf    (w_hn_ovf),
    .i_bd     (w_hn_bd),
    .o_valid  (w_h_valid),
    .o_pc     (w_h_pc),
    .o_instr  (w_h_instr),
    .o_data   (w_h_data),
    .o_exc    (w_h_exc),
    .o_bd     (w_h_bd)
  );

  // Stage: skid register (flush clears it completely, PC included)
  stage_entry_reg #(
    .NFIELD  (NFIELD),
    .EXC_W   (EXC_W),
    .OVF_EXC (OVF_EXC),
    .OVF_EN  (OVF_EN)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (flush),
    .i_clr_pc (32'h0),
    .i_load   (w_s_load),
    .i_kill   (w_s_kill),
    .i_pc     (in_pc),
    .i_instr  (in_instr),
    .i_data   (in_data),
    .i_exc    (in_exc),
    .i_ovf    (in_ovf),
    .i_bd     (in_bd),
    .o_valid  (w_s_valid),
    .o_pc     (w_s_pc),
    .o_instr  (w_s_instr),
    .o_data   (w_s_data),
    .o_exc    (w_s_exc),
    .o_bd     (w_s_bd)
  );

  assign out_valid = w_h_valid;
  assign out_pc    = w_h_pc;
  assign out_instr = w_h_instr;
  assign out_data  = w_h_data;
  assign out_exc   = w_h_exc;
  assign out_bd    = w_h_bd;
  assign out_count = {1'b0, w_h_valid} + {1'b0, w_s_valid};

  // Forward mux: unused codes (memory read not yet available) return 0.
  always_comb begin
    w_fwd = 32'h0;
    for (int k = FWD_SRC_CALRES; k < NFIELD; k++) begin
      if (fwd_sel == SEL_W'(k))
        w_fwd = w_h_data[32*k +: 32];
    end
    if (fwd_sel == SEL_W'(FWD_SRC_PC8))
      w_fwd = pc_plus8(w_h_pc);
  end

  assign fwd_src = w_fwd;

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;
  import pipe_stage_buf_pkg::*;

  localparam int NF = 2;

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [32*NF-1:0] data;
    logic [4:0]       exc;
    logic [4:0]       exc0;
    logic             bd;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, flush, in_valid, in_ovf, in_bd, out_ready;
  logic [31:0]      flush_pc, in_pc, in_instr;
  logic [32*NF-1:0] in_data;
  logic [4:0]       in_exc;
  logic [2:0]       fwd_sel;

  logic             in_ready, out_valid, out_bd;
  logic [31:0]      out_pc, out_instr, fwd_src;
  logic [32*NF-1:0] out_data;
  logic [4:0]       out_exc;
  logic [1:0]       out_count;

  logic             n_in_ready, n_out_valid, n_out_bd;
  logic [31:0]      n_out_pc, n_out_instr, n_fwd_src;
  logic [32*NF-1:0] n_out_data;
  logic [4:0]       n_out_exc;
  logic [1:0]       n_out_count;

  pipe_stage_buf #(.NFIELD(NF), .EXC_W(5), .OVF_EXC(12), .OVF_EN(1), .SEL_W(3)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_data(in_data), .in_exc(in_exc), .in_ovf(in_ovf), .in_bd(in_bd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_data(out_data), .out_exc(out_exc), .out_bd(out_bd),
    .out_count(out_count), .fwd_sel(fwd_sel), .fwd_src(fwd_src));

  pipe_stage_buf #(.NFIELD(NF), .EXC_W(5), .OVF_EXC(12), .OVF_EN(0), .SEL_W(3)) dut_n (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_data(in_data), .in_exc(in_exc), .in_ovf(in_ovf), .in_bd(in_bd),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
    .out_instr(n_out_instr), .out_data(n_out_data), .out_exc(n_out_exc), .out_bd(n_out_bd),
    .out_count(n_out_count), .fwd_sel(fwd_sel), .fwd_src(n_fwd_src));

  int   total = 0;
  int   bad   = 0;
  int   nfire = 0;
  bit   mon_en = 1'b0;
  ent_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference forward value computed from the entry contents.
  function automatic logic [31:0] fwd_model(input ent_t e, input logic [2:0] sel);
    if (int'(sel) < NF) return 32'(e.data >> (32 * int'(sel)));
    if (int'(sel) == NF) return e.pc + 32'd8;
    return 32'h0;
  endfunction

  // Model: a FIFO of stored entries; capacity 2; flush/reset empty it.
  task automatic step();
    bit   acc;
    ent_t e;
    acc     = in_valid && (q.size() < 2) && !flush && !reset;
    e.pc    = in_pc;
    e.instr = in_instr;
    e.data  = in_data;
    e.exc   = (in_exc != 0) ? in_exc : (in_ovf ? 5'd12 : 5'd0);
    e.exc0  = in_exc;
    e.bd    = in_bd;
    @(posedge clk);
    if (reset || flush) q.delete();
    else if (acc) q.push_back(e);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = $urandom;
    in_data  = {$urandom, $urandom};
    in_exc   = 5'd0;
    in_ovf   = 1'b0;
    in_bd    = 1'($urandom_range(0, 1));
  endtask

  // Monitor: state checks every cycle, scoreboard pop on each transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      ent_t e;
      chk("count", 64'(out_count), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("illegal_state", 64'(dut.w_s_valid & ~dut.w_h_valid), 64'(0));
      if (out_valid && out_ready && !flush && !reset) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = q.pop_front();
          nfire++;
          chk("out_pc", 64'(out_pc), 64'(e.pc));
          chk("out_instr", 64'(out_instr), 64'(e.instr));
          chk("out_data", out_data, e.data);
          chk("out_exc", 64'(out_exc), 64'(e.exc));
          chk("out_bd", 64'(out_bd), 64'(e.bd));
          chk("fwd_src", 64'(fwd_src), 64'(fwd_model(e, fwd_sel)));
          chk("noovf_pc", 64'(n_out_pc), 64'(e.pc));
          chk("noovf_exc", 64'(n_out_exc), 64'(e.exc0));
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_pc"}, 64'(out_pc), 64'(0));
    chk({tag, "_instr"}, 64'(out_instr), 64'(0));
    chk({tag, "_data"}, out_data, 64'(0));
    chk({tag, "_exc"}, 64'(out_exc), 64'(0));
    chk({tag, "_bd"}, 64'(out_bd), 64'(0));
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_count"}, 64'(out_count), 64'(0));
    chk({tag, "_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    int base;
    reset = 1'b1; flush = 1'b0; flush_pc = PC_KERNEL;
    out_ready = 1'b0; fwd_sel = 3'd0;
    set_in(1'b0, 32'h0);
    @(posedge clk); #1;
    step();
    mon_en = 1'b1;
    step();
    reset = 1'b0;
    chk_zero("reset");

    // 1: single entry, 1-cycle latency, forward select
    set_in(1'b1, 32'h3000);
    in_data = {32'hAAAA_0001, 32'h5};
    step();
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_pc", 64'(out_pc), 64'h3000);
    chk("t1_count", 64'(out_count), 64'(1));
    fwd_sel = 3'd0; #1;
    chk("t1_fwd0", 64'(fwd_src), 64'h5);
    fwd_sel = 3'(NF); #1;
    chk("t1_fwdpc8", 64'(fwd_src), 64'h3008);
    out_ready = 1'b1;
    step();
    step();

    // 2: fill skid, hold a third input, drain in order
    out_ready = 1'b0;
    set_in(1'b1, 32'h3000); step();
    set_in(1'b1, 32'h3004); step();
    chk("t2_count", 64'(out_count), 64'(2));
    chk("t2_ready", 64'(in_ready), 64'(0));
    set_in(1'b1, 32'h3008); step(); step();
    chk("t2_held_count", 64'(out_count), 64'(2));
    base = nfire;
    out_ready = 1'b1;
    step(); step();
    in_valid = 1'b0;
    step(); step();
    chk("t2_nout", 64'(nfire - base), 64'(3));

    // 3: flush with a full stage and an offered input
    out_ready = 1'b0;
    set_in(1'b1, 32'h3000); step();
    set_in(1'b1, 32'h3004); step();
    set_in(1'b1, 32'hDEAD_0000);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3_valid", 64'(out_valid), 64'(0));
    chk("t3_pc", 64'(out_pc), 64'(PC_KERNEL));
    chk("t3_instr", 64'(out_instr), 64'(0));
    chk("t3_count", 64'(out_count), 64'(0));
    chk("t3_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    step(); step();

    // 4: exception merging (OVF_EN=1 on dut, OVF_EN=0 on dut_n)
    out_ready = 1'b0;
    set_in(1'b1, 32'h3100); in_ovf = 1'b1; step();
    in_valid = 1'b0;
    chk("t4_ovf_exc", 64'(out_exc), 64'(12));
    chk("t4_noen_exc", 64'(n_out_exc), 64'(0));
    out_ready = 1'b1; step(); out_ready = 1'b0;
    set_in(1'b1, 32'h3104); in_exc = 5'd4; in_ovf = 1'b1; step();
    in_valid = 1'b0;
    chk("t4_early_exc", 64'(out_exc), 64'(4));
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // 5: forward decode edges
    set_in(1'b1, 32'hFFFF_FFFC); step();
    in_valid = 1'b0;
    fwd_sel = 3'(NF); #1;
    chk("t5_pc8_wrap", 64'(fwd_src), 64'h4);
    fwd_sel = 3'd7; #1;
    chk("t5_unused", 64'(fwd_src), 64'h0);
    out_ready = 1'b1; step();

    // 6: streaming at full throughput, then reset mid-stream
    base = nfire;
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 32'h1000 + 32'(4 * i));
      fwd_sel = 3'($urandom_range(0, 7));
      step();
      chk("t6_ready", 64'(in_ready), 64'(1));
      chk("t6_count", 64'(out_count), 64'(1));
    end
    in_valid = 1'b0;
    step();
    chk("t6_nout", 64'(nfire - base), 64'(16));
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h2000 + 32'(4 * i)); step();
    end
    reset = 1'b1; step();
    reset = 1'b0; in_valid = 1'b0;
    chk_zero("midreset");

    // Random traffic against the FIFO model
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), $urandom);
      if ($urandom_range(0, 3) == 0) in_exc = 5'($urandom_range(1, 31));
      in_ovf    = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 2) != 0);
      fwd_sel   = 3'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 39) == 0);
      flush_pc  = ($urandom_range(0, 1) == 0) ? PC_KERNEL : $urandom;
      reset     = ($urandom_range(0, 149) == 0);
      step();
    end
    flush = 1'b0; reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("drain_empty", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
